// File: rtl/coremacfilter_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : coremacfilter_sync_pkg
// Brief   : Shared constants and width helper for the synchronizer/filter family.
// Revision: 1.0 - initial release
// ============================================================================
package coremacfilter_sync_pkg;

    localparam int c_SYNC_STG_DEFAULT = 2;
    localparam int c_FILT_CNT_DEFAULT = 4;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/coremacfilter_sync_filt_ch.sv
`default_nettype none
// ============================================================================
// Module  : coremacfilter_sync_filt_ch
// Brief   : One channel: sync chain, stability counter, filtered level, edge pulses.
//           COREMACFILTER_SYNC_META_EN (simulation only) randomises first-stage capture.
// Revision: 1.0 - initial release
// ============================================================================
module coremacfilter_sync_filt_ch
    import coremacfilter_sync_pkg::*;
#(
    parameter int   SYNC_STG = c_SYNC_STG_DEFAULT,
    parameter int   FILT_CNT = c_FILT_CNT_DEFAULT,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_dout,
    output logic o_rise,
    output logic o_fall,
    output logic o_upd
);

    localparam int              CW         = clog2_min1(FILT_CNT);
    localparam logic [CW-1:0]   c_CNT_TERM = CW'(FILT_CNT - 1);

    logic [SYNC_STG-1:0] r_sync;
    logic [CW-1:0]       r_cnt;
    logic                r_dout;
    logic                r_rise;
    logic                r_fall;

    logic w_ss;
    logic w_diff;
    logic w_term;
    logic w_upd;

    assign w_ss   = r_sync[SYNC_STG-1];
    assign w_diff = w_ss ^ r_dout;
    assign w_term = (r_cnt == c_CNT_TERM);
    assign w_upd  = w_diff & w_term;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STG{RST_VAL}};
            r_cnt  <= '0;
            r_dout <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
`ifdef COREMACFILTER_SYNC_META_EN
            // A changing input may keep the old value for one extra cycle.
            r_sync[0] <= i_din ^ ((i_din ^ r_sync[0]) & 1'($random));
`else
            r_sync[0] <= i_din;
`endif
            r_sync[SYNC_STG-1:1] <= r_sync[SYNC_STG-2:0];

            // Any return to the current level, or terminal count, restarts the count.
            if (!w_diff || w_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_upd) begin
                r_dout <= w_ss;
            end
            r_rise <= w_upd & w_ss;
            r_fall <= w_upd & ~w_ss;
        end
    end

    assign o_dout = r_dout;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_upd  = w_upd;

endmodule
`default_nettype wire

// File: rtl/coremacfilter_sync_filt.sv
`default_nettype none
// ============================================================================
// Module  : coremacfilter_sync_filt
// Brief   : Multi-channel synchronizer with glitch filter and rise/fall/change pulses.
//           COREMACFILTER_SYNC_META_EN (simulation only) enables metastability modelling.
// Revision: 1.0 - initial release
// ============================================================================
module coremacfilter_sync_filt
    import coremacfilter_sync_pkg::*;
#(
    parameter int             NCH      = 1,
    parameter int             SYNC_STG = c_SYNC_STG_DEFAULT,
    parameter int             FILT_CNT = c_FILT_CNT_DEFAULT,
    parameter logic [NCH-1:0] RST_VAL  = '0
) (
    input  logic           dclk_i,
    input  logic           drst_ni,
    input  logic [NCH-1:0] din_i,
    output logic [NCH-1:0] dout_o,
    output logic [NCH-1:0] rise_o,
    output logic [NCH-1:0] fall_o,
    output logic           chg_o
);

    logic [NCH-1:0] w_upd;
    logic           r_chg;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        coremacfilter_sync_filt_ch #(
            .SYNC_STG (SYNC_STG),
            .FILT_CNT (FILT_CNT),
            .RST_VAL  (RST_VAL[c])
        ) u_ch (
            .i_clk   (dclk_i),
            .i_rst_n (drst_ni),
            .i_din   (din_i[c]),
            .o_dout  (dout_o[c]),
            .o_rise  (rise_o[c]),
            .o_fall  (fall_o[c]),
            .o_upd   (w_upd[c])
        );
    end

    // Registered from the same update strobes so it lines up with the pulses.
    always_ff @(posedge dclk_i) begin
        if (!drst_ni) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= |w_upd;
        end
    end

    assign chg_o = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_coremacfilter_sync_filt.sv
`default_nettype none
// ============================================================================
// Module  : tb_coremacfilter_sync_filt
// Brief   : Directed table-driven bench for the synchronizer/filter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_coremacfilter_sync_filt;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic [3:0] dout, rise, fall;
    logic       chg;
    logic [0:0] din2, dout2, rise2, fall2;
    logic       chg2;

    int checks = 0;
    int errors = 0;

    coremacfilter_sync_filt #(
        .NCH(4), .SYNC_STG(2), .FILT_CNT(4), .RST_VAL(4'b1010)
    ) dut (
        .dclk_i(clk), .drst_ni(rst_n), .din_i(din),
        .dout_o(dout), .rise_o(rise), .fall_o(fall), .chg_o(chg)
    );

    coremacfilter_sync_filt #(
        .NCH(1), .SYNC_STG(3), .FILT_CNT(1), .RST_VAL(1'b0)
    ) dut2 (
        .dclk_i(clk), .drst_ni(rst_n), .din_i(din2),
        .dout_o(dout2), .rise_o(rise2), .fall_o(fall2), .chg_o(chg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] din;
        int         rep;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] d, input int n,
                       input logic [3:0] eo, input logic [3:0] er,
                       input logic [3:0] ef, input logic ec);
        vec_t v;
        v.rst_n = r; v.din = d; v.rep = n;
        v.dout = eo; v.rise = er; v.fall = ef; v.chg = ec;
        vecs.push_back(v);
    endtask

    logic h[0:31];
    logic e_prev, e_cur, e_rise, e_fall;

    initial begin
        rst_n = 1'b0;
        din   = 4'b0101;
        din2  = 1'b0;

        // Reset hold, then release with every channel opposite to RST_VAL.
        add(0, 4'b0101, 3, 4'b1010, 4'b0000, 4'b0000, 0);
        add(1, 4'b0101, 5, 4'b1010, 4'b0000, 4'b0000, 0);
        add(1, 4'b0101, 1, 4'b0101, 4'b0101, 4'b1010, 1);
        add(1, 4'b0101, 2, 4'b0101, 4'b0000, 4'b0000, 0);
        // Latency on ch0: fall then rise, each on edge 6.
        add(1, 4'b0100, 5, 4'b0101, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0001, 1);
        add(1, 4'b0100, 2, 4'b0100, 4'b0000, 4'b0000, 0);
        add(1, 4'b0101, 5, 4'b0100, 4'b0000, 4'b0000, 0);
        add(1, 4'b0101, 1, 4'b0101, 4'b0001, 4'b0000, 1);
        add(1, 4'b0101, 2, 4'b0101, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 5, 4'b0101, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0001, 1);
        add(1, 4'b0100, 2, 4'b0100, 4'b0000, 4'b0000, 0);
        // 3-cycle glitch is suppressed.
        add(1, 4'b0101, 3, 4'b0100, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 8, 4'b0100, 4'b0000, 4'b0000, 0);
        // 4-cycle pulse passes: one rise, then one fall.
        add(1, 4'b0101, 4, 4'b0100, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 1, 4'b0101, 4'b0001, 4'b0000, 1);
        add(1, 4'b0100, 3, 4'b0101, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0001, 1);
        add(1, 4'b0100, 2, 4'b0100, 4'b0000, 4'b0000, 0);
        // Simultaneous ch0 rise and ch2 fall.
        add(1, 4'b0001, 5, 4'b0100, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0100, 1);
        add(1, 4'b0001, 2, 4'b0001, 4'b0000, 4'b0000, 0);
        // ch1 count reaches 2, then reset aborts it.
        add(1, 4'b0011, 4, 4'b0001, 4'b0000, 4'b0000, 0);
        add(0, 4'b0011, 2, 4'b1010, 4'b0000, 4'b0000, 0);
        // After release only ch1 differs; it must need the full 6 edges.
        add(1, 4'b1000, 5, 4'b1010, 4'b0000, 4'b0000, 0);
        add(1, 4'b1000, 1, 4'b1000, 4'b0000, 4'b0010, 1);
        add(1, 4'b1000, 2, 4'b1000, 4'b0000, 4'b0000, 0);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                rst_n = vecs[i].rst_n;
                din   = vecs[i].din;
                @(posedge clk);
                #1;
                checks++;
                if ({dout, rise, fall, chg} !==
                    {vecs[i].dout, vecs[i].rise, vecs[i].fall, vecs[i].chg}) begin
                    errors++;
                    $display("FAIL vec%0d.%0d dout/rise/fall/chg got %b/%b/%b/%b want %b/%b/%b/%b",
                             i, r, dout, rise, fall, chg,
                             vecs[i].dout, vecs[i].rise, vecs[i].fall, vecs[i].chg);
                end
            end
        end

        // FILT_CNT=1, SYNC_STG=3 instance: follows din2 with a 4-edge latency.
        e_prev = 1'b0;
        for (int k = 0; k < 32; k++) begin
            din2 = 1'((k / 4) % 2);
            h[k] = din2[0];
            @(posedge clk);
            #1;
            e_cur  = (k >= 3) ? h[k-3] : 1'b0;
            e_rise = e_cur & ~e_prev;
            e_fall = ~e_cur & e_prev;
            checks++;
            if ({dout2, rise2, fall2, chg2} !== {e_cur, e_rise, e_fall, e_rise | e_fall}) begin
                errors++;
                $display("FAIL fc1 cyc%0d dout/rise/fall/chg got %b/%b/%b/%b want %b/%b/%b/%b",
                         k, dout2, rise2, fall2, chg2, e_cur, e_rise, e_fall, e_rise | e_fall);
            end
            e_prev = e_cur;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
